// File: rtl/alu_shl_sequencer.sv
// alu_shl_sequencer: two-port round-robin front end for a shared iterative
// shift-left unit; shifts one bit per clock and returns the result over valid/ready.
module alu_shl_sequencer #(
   parameter int WIDTH = 3,
   parameter int SHW   = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [WIDTH-1:0] req0_a_i,
   input  logic [SHW-1:0]   req0_b_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [WIDTH-1:0] req1_a_i,
   input  logic [SHW-1:0]   req1_b_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [WIDTH-1:0] res_r_o,
   output logic             res_id_o,
   output logic             res_ovf_o
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             id_q, id_d, ovf_q, ovf_d, prio_q, prio_d;
   logic             both, grant, take;
   logic [SHW-1:0]   sel_b;
   assign both  = req0_valid_i & req1_valid_i;
   assign grant = both ? prio_q : req1_valid_i;
   assign sel_b = grant ? req1_b_i : req0_b_i;
   // readies are gated by reset so nothing is accepted while rst_ni is low
   assign req0_ready_o = rst_ni & (state_q == IDLE) & req0_valid_i & ~grant;
   assign req1_ready_o = rst_ni & (state_q == IDLE) & req1_valid_i & grant;
   assign take         = req0_ready_o | req1_ready_o;
   assign res_valid_o  = state_q == DONE;
   assign res_r_o      = acc_q;
   assign res_id_o     = id_q;
   assign res_ovf_o    = ovf_q;
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      ovf_d   = ovf_q;
      prio_d  = prio_q;
      if (state_q == IDLE && take) begin
         acc_d   = grant ? req1_a_i : req0_a_i;
         cnt_d   = sel_b;
         id_d    = grant;
         ovf_d   = 1'b0;
         prio_d  = both ? ~grant : prio_q;
         state_d = (sel_b != '0) ? SHIFT : DONE;
      end else if (state_q == SHIFT) begin
         ovf_d   = ovf_q | acc_q[WIDTH-1];
         acc_d   = {acc_q[WIDTH-2:0], 1'b0};
         cnt_d   = cnt_q - SHW'(1);
         state_d = (cnt_q == SHW'(1)) ? DONE : SHIFT;
      end else if (state_q == DONE && res_ready_i) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         id_q    <= 1'b0;
         ovf_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         ovf_q   <= ovf_d;
         prio_q  <= prio_d;
      end
   end
endmodule

// File: tb/tb_alu_shl_sequencer.sv
// tb_alu_shl_sequencer: scoreboard bench; expected results are queued at accept
// and compared at the result handshake, together with latency and arbitration order.
module tb_alu_shl_sequencer;
   localparam int W = 3;
   localparam int S = 2;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         r0v, r0r, r1v, r1r, rv, rr, rid, rovf;
   logic [W-1:0] r0a, r1a, rres;
   logic [S-1:0] r0b, r1b;
   typedef struct {
      logic [W-1:0] r;
      logic         id;
      logic         ovf;
      int           due;
   } exp_t;
   exp_t q[$];
   logic acc_log[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_acc = 0;
   logic prio_m = 1'b0;
   logic g_m;
   bit   seen = 0;
   always #5 clk = ~clk;
   alu_shl_sequencer #(.WIDTH(W), .SHW(S)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(r0v), .req0_ready_o(r0r), .req0_a_i(r0a), .req0_b_i(r0b),
      .req1_valid_i(r1v), .req1_ready_o(r1r), .req1_a_i(r1a), .req1_b_i(r1b),
      .res_valid_o(rv), .res_ready_i(rr), .res_r_o(rres), .res_id_o(rid), .res_ovf_o(rovf)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // reference: shift in a wide word, low bits are the result, high bits the lost ones
   function automatic exp_t model(input logic [W-1:0] a, input logic [S-1:0] b, input logic id, input int due);
      logic [W+7:0] full;
      exp_t e;
      full  = {8'b0, a} << b;
      e.r   = full[W-1:0];
      e.ovf = |full[W+7:W];
      e.id  = id;
      e.due = due;
      return e;
   endfunction
   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         q.delete();
         prio_m = 1'b0;
         seen = 0;
      end else begin
         check("one_ready", r0r & r1r, 0);
         if (rv) begin
            if (q.size() == 0) check("spurious_res", 1, 0);
            else begin
               if (!seen) begin
                  check("latency", cyc, q[0].due);
                  seen = 1;
               end
               if (rr) begin
                  check("res_r", rres, q[0].r);
                  check("res_id", rid, q[0].id);
                  check("res_ovf", rovf, q[0].ovf);
                  void'(q.pop_front());
                  seen = 0;
               end
            end
         end
         if (r0r | r1r) begin
            g_m = r1r;
            if (r0v & r1v) begin
               check("arb_prio", g_m, prio_m);
               prio_m = ~g_m;
            end
            n_acc++;
            acc_log.push_back(g_m);
            q.push_back(model(g_m ? r1a : r0a, g_m ? r1b : r0b, g_m, cyc + int'(g_m ? r1b : r0b) + 1));
         end
      end
   end
   task automatic issue(input logic p, input logic [W-1:0] a, input logic [S-1:0] b);
      bit ok = 0;
      if (p) begin r1a = a; r1b = b; r1v = 1'b1; end
      else begin r0a = a; r0b = b; r0v = 1'b1; end
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = p ? r1r : r0r;
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (p) r1v = 1'b0; else r0v = 1'b0;
   endtask
   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = (q.size() == 0) && !rv;
      end
      if (!ok) check("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   initial begin
      bit ok;
      int base;
      rst_n = 1'b0;
      r0v = 1'b1; r1v = 1'b0; r0a = '0; r1a = '0; r0b = '0; r1b = '0; rr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_res_valid", rv, 0);
      check("rst_res_r", rres, 0);
      check("rst_res_id", rid, 0);
      check("rst_res_ovf", rovf, 0);
      check("rst_req0_ready", r0r, 0);
      @(posedge clk);
      #1 rst_n = 1'b1; r0v = 1'b0;
      issue(0, 3'b011, 2'd1); drain();
      issue(1, 3'b101, 2'd0); drain();
      issue(0, 3'b101, 2'd3); drain();
      issue(0, 3'b001, 2'd2); drain();
      for (int i = 0; i < 12; i++) issue(1'($urandom_range(1)), 3'($urandom), 2'($urandom));
      drain();
      do_reset();
      acc_log.delete();
      base = n_acc;
      r0a = 3'b011; r0b = 2'd1; r1a = 3'b110; r1b = 2'd2;
      r0v = 1'b1; r1v = 1'b1;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk);
         ok = n_acc >= base + 4;
      end
      #1 r0v = 1'b0; r1v = 1'b0;
      if (!ok) check("arb_timeout", 0, 1);
      for (int k = 0; k < 4; k++) check("arb_order", acc_log.size() > k ? acc_log[k] : 1'bx, k[0]);
      drain();
      r1a = 3'b010; r1b = 2'd1; r1v = 1'b1;
      @(negedge clk);
      check("lone_req1_ready", r1r, 1);
      @(posedge clk);
      #1 r1v = 1'b0;
      drain();
      rr = 1'b0;
      issue(0, 3'b111, 2'd2);
      r1a = 3'b010; r1b = 2'd1; r1v = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = rv;
      end
      if (!ok) check("bp_valid_timeout", 0, 1);
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", rv, 1);
         check("bp_r", rres, 3'b100);
         check("bp_id", rid, 0);
         check("bp_ovf", rovf, 1);
         check("bp_readies", r0r | r1r, 0);
      end
      @(posedge clk);
      #1 rr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_next_accept", r1r, 1);
      @(posedge clk);
      #1 r1v = 1'b0;
      drain();
      r0a = 3'b101; r0b = 2'd3; r1a = 3'b101; r1b = 2'd3;
      r0v = 1'b1; r1v = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = r0r | r1r;
      end
      if (!ok) check("mid_accept_timeout", 0, 1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_prio_req0", r0r, 1);
      check("rst_prio_req1", r1r, 0);
      @(posedge clk);
      #1 r0v = 1'b0; r1v = 1'b0;
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_shl_sequencer.md
# alu_shl_sequencer

Multi-cycle controller that shares one left-shift datapath between two requesters. It arbitrates round-robin between the two request ports and captures the winning operand. It then performs the shift as one single-bit left shift per clock, so arbitrary shift amounts are handled iteratively. The result is returned through a valid/ready result port. It sits between the ALU operand issue logic and the ALU result mux, and is the sequenced replacement for the purely combinational shift-left path.

## Interface
- WIDTH, 3: operand/result width in bits.
- SHW, 2: shift-amount width in bits; shift amounts range 0 .. 2^SHW-1.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 accepted this cycle (transfer when valid & ready).
- req0_a  input  WIDTH  requester 0 operand.
- req0_b  input  SHW  requester 0 shift amount.
- req1_valid / req1_ready / req1_a / req1_b: same as requester 0, for requester 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result (transfer when valid & ready).
- res_r  output  WIDTH  shifted result.
- res_id  output  1  index of the requester that issued this result.
- res_ovf  output  1  OR of every bit shifted out of the MSB during the operation.

## Operation
- Internal state: fsm (IDLE, SHIFT, DONE), acc[WIDTH], cnt[SHW], id, ovf, prio (1 bit, the requester favoured on a tie).
- IDLE: grant = prio if both valid; otherwise the single valid requester.
  - reqX_ready = (fsm==IDLE) & reqX_valid & (grant==X). This is combinational; at most one ready is high.
  - On a transfer: acc<=reqX_a, cnt<=reqX_b, id<=X, ovf<=0.
  - If both requesters were valid, prio <= ~X. If only one was valid, prio is unchanged.
  - Next state is SHIFT if reqX_b!=0, else DONE.
- SHIFT: each cycle ovf<=ovf|acc[WIDTH-1], acc<={acc[WIDTH-2:0],1'b0}, cnt<=cnt-1. When cnt==1, next state is DONE.
- DONE: res_valid=1.
  - res_r=acc, res_id=id, res_ovf=ovf, all held stable until res_ready.
  - On res_ready, next state is IDLE.
  - No request is accepted while in SHIFT or DONE.
- Arithmetic rules:
  - Shift amount >= WIDTH gives res_r=0 and res_ovf=|a.
  - Shift amount 0 gives res_r=a and res_ovf=0.
  - No wrap-around: zeros always fill from the LSB.
- Outputs res_r/res_id/res_ovf read the internal registers directly; consumers must treat them as meaningful only while res_valid=1.

## Timing
- Reset (rst_n=0 at a rising edge) gives:
  - fsm=IDLE, acc=0, cnt=0, id=0, ovf=0, prio=0.
  - res_valid=0, res_r=0, res_id=0, res_ovf=0.
  - req0_ready/req1_ready follow the IDLE equation after reset; they are 0 while rst_n=0.
- Reset mid-operation (SHIFT or DONE) discards the operation; no res_valid is produced for it.
- Latency: an accept at edge T gives res_valid high from edge T+b+1, i.e. b shift cycles plus one DONE-entry cycle. For b=0, res_valid is high the cycle after accept.
- Throughput: one operation per b+2 cycles minimum.
  - A res_ready already high on the first DONE cycle gives the sequence IDLE, SHIFT×b, DONE.
  - The earliest next accept is in the IDLE cycle after the DONE handshake.
- Simultaneous events:
  - Both requests valid in IDLE: only the prio requester is accepted; the other keeps valid and is served next.
  - A request arriving during SHIFT/DONE waits with ready=0 and must hold its operands stable.
- Backpressure: while res_valid=1 and res_ready=0, all result outputs hold their values and both readies stay 0.

## Test plan
- Single shift: after reset, req0 a=3'b011, b=1 → req0_ready same cycle. Two cycles later res_valid=1 with res_r=3'b110, res_ovf=0, res_id=0.
- Zero shift: req1 a=3'b101, b=0 → res_valid on the next cycle with res_r=3'b101, res_ovf=0, res_id=1.
- Over-shift: req0 a=3'b101, b=3 → res_valid 4 cycles after accept with res_r=3'b000, res_ovf=1. Also a=3'b001, b=2 → res_r=3'b100, res_ovf=0.
- Arbitration: both requesters held valid continuously from reset with res_ready=1 → accepted res_id sequence is 0,1,0,1. A lone req1 never waits on prio.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_r/res_id/res_ovf stable, req readies 0. Release → IDLE next cycle, then the pending request is accepted.
- Reset mid-SHIFT: req0 b=3, assert rst_n=0 one cycle after accept → next cycle fsm IDLE, res_valid never asserts for that op, prio=0.
